// File: rtl/axi_slice_cfg_if.sv
// axi_slice_cfg_if: request/response bundle for one AXI port.
// master drives req and reads resp; slave does the reverse.
interface axi_slice_cfg_if #(
  parameter type req_t  = logic,
  parameter type resp_t = logic
) ();
  req_t  req;
  resp_t resp;

  modport master (
    output req,
    input  resp
  );

  modport slave (
    input  req,
    output resp
  );
endinterface

// File: rtl/axi_slice_cfg.sv
// axi_slice_cfg: AXI4 slice with per-channel mode (0 bypass, 1 fwd,
// 2 bwd, 3 full spill). Ports: clk_i, rst_ni, slv/mst req/resp, idle_o.
package axi_slice_cfg_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    b_chan_t  b;
    logic     b_valid;
    r_chan_t  r;
    logic     r_valid;
  } resp_t;
endpackage

module axi_slice_cfg_chan #(
  parameter int unsigned Mode = 3,
  parameter type data_t = logic
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  output logic       ready_o,
  input  data_t      data_i,
  output logic       valid_o,
  output data_t      data_o,
  input  logic       ready_i,
  output logic [1:0] occ_o
);
  localparam logic [1:0] OccMax =
    (Mode == 0) ? 2'd0 : (Mode == 3) ? 2'd2 : 2'd1;

  // push/pop refer to beats entering/leaving stored entries
  logic push, pop;

  if (Mode > 3) begin : g_bad
    $fatal(1, "axi_slice_cfg: mode %0d out of range", Mode);
  end

  if (Mode == 0) begin : g_byp
    assign ready_o = ready_i;
    assign valid_o = valid_i;
    assign data_o  = data_i;
    assign push    = 1'b0;
    assign pop     = 1'b0;
    assign occ_o   = 2'd0;
  end else if (Mode == 1) begin : g_fwd
    data_t d_q, d_d;
    logic  f_q, f_d;

    // ready stays combinational from ready_i to keep full rate
    assign ready_o = ~f_q | ready_i;
    assign valid_o = f_q;
    assign data_o  = d_q;
    assign push    = valid_i & ready_o;
    assign pop     = f_q & ready_i;
    assign occ_o   = {1'b0, f_q};

    always_comb begin
      d_d = d_q;
      f_d = f_q;
      if (push) begin
        d_d = data_i;
        f_d = 1'b1;
      end else if (pop) begin
        f_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        d_q <= '0;
        f_q <= 1'b0;
      end else begin
        d_q <= d_d;
        f_q <= f_d;
      end
    end
  end else if (Mode == 2) begin : g_bwd
    data_t d_q, d_d;
    logic  f_q, f_d;

    // empty: pass-through; skid only when the sink stalls
    assign ready_o = ~f_q;
    assign valid_o = f_q | valid_i;
    assign data_o  = f_q ? d_q : data_i;
    assign push    = valid_i & ~f_q & ~ready_i;
    assign pop     = f_q & ready_i;
    assign occ_o   = {1'b0, f_q};

    always_comb begin
      d_d = d_q;
      f_d = f_q;
      if (push) begin
        d_d = data_i;
        f_d = 1'b1;
      end else if (pop) begin
        f_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        d_q <= '0;
        f_q <= 1'b0;
      end else begin
        d_q <= d_d;
        f_q <= f_d;
      end
    end
  end else begin : g_full
    data_t a_q, a_d, b_q, b_d;
    logic  af_q, af_d, bf_q, bf_d;

    // a is the output entry, b the spill; b is only used when a is held
    assign ready_o = ~bf_q;
    assign valid_o = af_q;
    assign data_o  = a_q;
    assign push    = valid_i & ~bf_q;
    assign pop     = af_q & ready_i;
    assign occ_o   = 2'(af_q) + 2'(bf_q);

    always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      af_d = af_q;
      bf_d = bf_q;
      if (pop) begin
        if (bf_q) begin
          a_d  = b_q;
          bf_d = 1'b0;
        end else if (push) begin
          a_d = data_i;
        end else begin
          af_d = 1'b0;
        end
      end else if (push) begin
        if (af_q) begin
          b_d  = data_i;
          bf_d = 1'b1;
        end else begin
          a_d  = data_i;
          af_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_q  <= '0;
        b_q  <= '0;
        af_q <= 1'b0;
        bf_q <= 1'b0;
      end else begin
        a_q  <= a_d;
        b_q  <= b_d;
        af_q <= af_d;
        bf_q <= bf_d;
      end
    end
  end

  a_occ_max: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    occ_o <= OccMax);

  a_no_under: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    pop |-> occ_o != 2'd0);

  a_no_over: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (push && !pop) |-> occ_o < OccMax);
endmodule

module axi_slice_cfg #(
  parameter int unsigned AwMode = 2'd3,
  parameter int unsigned WMode  = 2'd3,
  parameter int unsigned BMode  = 2'd3,
  parameter int unsigned ArMode = 2'd3,
  parameter int unsigned RMode  = 2'd3,
  parameter type aw_chan_t = axi_slice_cfg_pkg::aw_chan_t,
  parameter type w_chan_t  = axi_slice_cfg_pkg::w_chan_t,
  parameter type b_chan_t  = axi_slice_cfg_pkg::b_chan_t,
  parameter type ar_chan_t = axi_slice_cfg_pkg::ar_chan_t,
  parameter type r_chan_t  = axi_slice_cfg_pkg::r_chan_t,
  parameter type req_t     = axi_slice_cfg_pkg::req_t,
  parameter type resp_t    = axi_slice_cfg_pkg::resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i,
  output logic  idle_o
);
  aw_chan_t   aw_d;
  w_chan_t    w_d;
  b_chan_t    b_d;
  ar_chan_t   ar_d;
  r_chan_t    r_d;
  logic       aw_v, w_v, b_v, ar_v, r_v;
  logic       aw_r, w_r, b_r, ar_r, r_r;
  logic [1:0] aw_o, w_o, b_o, ar_o, r_o;

  axi_slice_cfg_chan #(.Mode(AwMode), .data_t(aw_chan_t)) u_aw (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.aw_valid), .ready_o(aw_r),
    .data_i (slv_req_i.aw),
    .valid_o(aw_v), .data_o(aw_d),
    .ready_i(mst_resp_i.aw_ready), .occ_o(aw_o)
  );

  axi_slice_cfg_chan #(.Mode(WMode), .data_t(w_chan_t)) u_w (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.w_valid), .ready_o(w_r),
    .data_i (slv_req_i.w),
    .valid_o(w_v), .data_o(w_d),
    .ready_i(mst_resp_i.w_ready), .occ_o(w_o)
  );

  axi_slice_cfg_chan #(.Mode(BMode), .data_t(b_chan_t)) u_b (
    .clk_i, .rst_ni,
    .valid_i(mst_resp_i.b_valid), .ready_o(b_r),
    .data_i (mst_resp_i.b),
    .valid_o(b_v), .data_o(b_d),
    .ready_i(slv_req_i.b_ready), .occ_o(b_o)
  );

  axi_slice_cfg_chan #(.Mode(ArMode), .data_t(ar_chan_t)) u_ar (
    .clk_i, .rst_ni,
    .valid_i(slv_req_i.ar_valid), .ready_o(ar_r),
    .data_i (slv_req_i.ar),
    .valid_o(ar_v), .data_o(ar_d),
    .ready_i(mst_resp_i.ar_ready), .occ_o(ar_o)
  );

  axi_slice_cfg_chan #(.Mode(RMode), .data_t(r_chan_t)) u_r (
    .clk_i, .rst_ni,
    .valid_i(mst_resp_i.r_valid), .ready_o(r_r),
    .data_i (mst_resp_i.r),
    .valid_o(r_v), .data_o(r_d),
    .ready_i(slv_req_i.r_ready), .occ_o(r_o)
  );

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = aw_d;
    mst_req_o.aw_valid = aw_v;
    mst_req_o.w        = w_d;
    mst_req_o.w_valid  = w_v;
    mst_req_o.b_ready  = b_r;
    mst_req_o.ar       = ar_d;
    mst_req_o.ar_valid = ar_v;
    mst_req_o.r_ready  = r_r;
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_r;
    slv_resp_o.ar_ready = ar_r;
    slv_resp_o.w_ready  = w_r;
    slv_resp_o.b        = b_d;
    slv_resp_o.b_valid  = b_v;
    slv_resp_o.r        = r_d;
    slv_resp_o.r_valid  = r_v;
  end

  // only occupancy flops feed idle_o
  assign idle_o = ~|{aw_o, w_o, b_o, ar_o, r_o};
endmodule

// File: tb/tb_axi_slice_cfg.sv
// tb_axi_slice_cfg: directed checks of axi_slice_cfg in mixed modes
// (AW/W/AR full, B fwd, R bwd) plus an all-bypass instance.
module tb_axi_slice_cfg;
  import axi_slice_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle, byp_idle;
  int   total = 0;
  int   fails = 0;
  logic [127:0] rq, rs;

  always #5 clk = ~clk;

  axi_slice_cfg_if #(.req_t(req_t), .resp_t(resp_t)) slv_bus ();
  axi_slice_cfg_if #(.req_t(req_t), .resp_t(resp_t)) mst_bus ();
  axi_slice_cfg_if #(.req_t(req_t), .resp_t(resp_t)) byp_slv ();
  axi_slice_cfg_if #(.req_t(req_t), .resp_t(resp_t)) byp_mst ();

  axi_slice_cfg #(
    .AwMode(3), .WMode(3), .BMode(1), .ArMode(3), .RMode(2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_bus.req),
    .slv_resp_o(slv_bus.resp),
    .mst_req_o (mst_bus.req),
    .mst_resp_i(mst_bus.resp),
    .idle_o    (idle)
  );

  axi_slice_cfg #(
    .AwMode(0), .WMode(0), .BMode(0), .ArMode(0), .RMode(0)
  ) dut_byp (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (byp_slv.req),
    .slv_resp_o(byp_slv.resp),
    .mst_req_o (byp_mst.req),
    .mst_resp_i(byp_mst.resp),
    .idle_o    (byp_idle)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    slv_bus.req  = '0;
    mst_bus.resp = '0;
    byp_slv.req  = '0;
    byp_mst.resp = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_aw_v", 32'(mst_bus.req.aw_valid), 32'd0);
    chk("rst_ar_v", 32'(mst_bus.req.ar_valid), 32'd0);
    chk("rst_w_v", 32'(mst_bus.req.w_valid), 32'd0);
    chk("rst_b_v", 32'(slv_bus.resp.b_valid), 32'd0);
    chk("rst_r_v", 32'(slv_bus.resp.r_valid), 32'd0);
    chk("rst_aw_rdy", 32'(slv_bus.resp.aw_ready), 32'd1);
    chk("rst_w_rdy", 32'(slv_bus.resp.w_ready), 32'd1);
    chk("rst_ar_rdy", 32'(slv_bus.resp.ar_ready), 32'd1);
    chk("rst_b_rdy", 32'(mst_bus.req.b_ready), 32'd1);
    chk("rst_r_rdy", 32'(mst_bus.req.r_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // bypass instance: wires, always idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rq = {$urandom(), $urandom(), $urandom(), $urandom()};
      rs = {$urandom(), $urandom(), $urandom(), $urandom()};
      byp_slv.req  = rq[$bits(req_t)-1:0];
      byp_mst.resp = rs[$bits(resp_t)-1:0];
      #1;
      chkw("byp_req", 128'(byp_mst.req), 128'(byp_slv.req));
      chkw("byp_resp", 128'(byp_slv.resp), 128'(byp_mst.resp));
      chk("byp_idle", 32'(byp_idle), 32'd1);
    end

    // AW full: back-to-back ids 1,2,3
    mst_bus.resp.aw_ready = 1'b1;
    @(negedge clk);
    slv_bus.req.aw_valid = 1'b1;
    slv_bus.req.aw.id = 4'd1;
    #1;
    chk("aw0_v", 32'(mst_bus.req.aw_valid), 32'd0);
    @(negedge clk);
    slv_bus.req.aw.id = 4'd2;
    #1;
    chk("aw1_v", 32'(mst_bus.req.aw_valid), 32'd1);
    chk("aw1_id", 32'(mst_bus.req.aw.id), 32'd1);
    @(negedge clk);
    slv_bus.req.aw.id = 4'd3;
    #1;
    chk("aw2_id", 32'(mst_bus.req.aw.id), 32'd2);
    chk("aw2_rdy", 32'(slv_bus.resp.aw_ready), 32'd1);
    @(negedge clk);
    slv_bus.req.aw_valid = 1'b0;
    #1;
    chk("aw3_id", 32'(mst_bus.req.aw.id), 32'd3);
    chk("aw3_idle", 32'(idle), 32'd0);
    @(negedge clk);
    #1;
    chk("aw4_v", 32'(mst_bus.req.aw_valid), 32'd0);
    chk("aw4_idle", 32'(idle), 32'd1);

    // W full: fill both entries with sink stalled
    @(negedge clk);
    slv_bus.req.w_valid = 1'b1;
    slv_bus.req.w.data = 32'hA5;
    #1;
    chk("w0_rdy", 32'(slv_bus.resp.w_ready), 32'd1);
    @(negedge clk);
    slv_bus.req.w.data = 32'h5A;
    #1;
    chk("w1_rdy", 32'(slv_bus.resp.w_ready), 32'd1);
    chk("w1_data", mst_bus.req.w.data, 32'hA5);
    @(negedge clk);
    slv_bus.req.w_valid = 1'b0;
    #1;
    chk("w2_rdy", 32'(slv_bus.resp.w_ready), 32'd0);
    chk("w2_data", mst_bus.req.w.data, 32'hA5);
    chk("w2_v", 32'(mst_bus.req.w_valid), 32'd1);
    mst_bus.resp.w_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("w3_data", mst_bus.req.w.data, 32'h5A);
    chk("w3_v", 32'(mst_bus.req.w_valid), 32'd1);
    chk("w3_rdy", 32'(slv_bus.resp.w_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("w4_v", 32'(mst_bus.req.w_valid), 32'd0);
    chk("w4_idle", 32'(idle), 32'd1);
    mst_bus.resp.w_ready = 1'b0;

    // R bwd: pass-through, then skid
    @(negedge clk);
    mst_bus.resp.r_valid = 1'b1;
    mst_bus.resp.r.data = 32'h11;
    slv_bus.req.r_ready = 1'b1;
    #1;
    chk("r0_v", 32'(slv_bus.resp.r_valid), 32'd1);
    chk("r0_data", slv_bus.resp.r.data, 32'h11);
    chk("r0_rdy", 32'(mst_bus.req.r_ready), 32'd1);
    @(negedge clk);
    mst_bus.resp.r.data = 32'h22;
    slv_bus.req.r_ready = 1'b0;
    #1;
    chk("r1_data", slv_bus.resp.r.data, 32'h22);
    chk("r1_idle", 32'(idle), 32'd1);
    @(negedge clk);
    mst_bus.resp.r_valid = 1'b0;
    mst_bus.resp.r.data = 32'h0;
    #1;
    chk("r2_rdy", 32'(mst_bus.req.r_ready), 32'd0);
    chk("r2_v", 32'(slv_bus.resp.r_valid), 32'd1);
    chk("r2_data", slv_bus.resp.r.data, 32'h22);
    chk("r2_idle", 32'(idle), 32'd0);
    slv_bus.req.r_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("r3_v", 32'(slv_bus.resp.r_valid), 32'd0);
    chk("r3_rdy", 32'(mst_bus.req.r_ready), 32'd1);

    // B fwd: OKAY then SLVERR, sink ready 1,0,1
    @(negedge clk);
    mst_bus.resp.b_valid = 1'b1;
    mst_bus.resp.b.id = 4'd1;
    mst_bus.resp.b.resp = 2'd0;
    slv_bus.req.b_ready = 1'b1;
    #1;
    chk("b0_v", 32'(slv_bus.resp.b_valid), 32'd0);
    chk("b0_rdy", 32'(mst_bus.req.b_ready), 32'd1);
    @(negedge clk);
    mst_bus.resp.b.id = 4'd2;
    mst_bus.resp.b.resp = 2'd2;
    slv_bus.req.b_ready = 1'b0;
    #1;
    chk("b1_v", 32'(slv_bus.resp.b_valid), 32'd1);
    chk("b1_id", 32'(slv_bus.resp.b.id), 32'd1);
    chk("b1_rdy", 32'(mst_bus.req.b_ready), 32'd0);
    @(negedge clk);
    slv_bus.req.b_ready = 1'b1;
    #1;
    chk("b2_id", 32'(slv_bus.resp.b.id), 32'd1);
    chk("b2_resp", 32'(slv_bus.resp.b.resp), 32'd0);
    chk("b2_rdy", 32'(mst_bus.req.b_ready), 32'd1);
    @(negedge clk);
    mst_bus.resp.b_valid = 1'b0;
    #1;
    chk("b3_v", 32'(slv_bus.resp.b_valid), 32'd1);
    chk("b3_id", 32'(slv_bus.resp.b.id), 32'd2);
    chk("b3_resp", 32'(slv_bus.resp.b.resp), 32'd2);
    @(negedge clk);
    #1;
    chk("b4_v", 32'(slv_bus.resp.b_valid), 32'd0);
    chk("b4_idle", 32'(idle), 32'd1);
    slv_bus.req.b_ready = 1'b0;

    // AR full: two beats held, then async reset
    mst_bus.resp.ar_ready = 1'b0;
    @(negedge clk);
    slv_bus.req.ar_valid = 1'b1;
    slv_bus.req.ar.id = 4'd5;
    #1;
    chk("ar0_rdy", 32'(slv_bus.resp.ar_ready), 32'd1);
    @(negedge clk);
    slv_bus.req.ar.id = 4'd6;
    #1;
    chk("ar1_rdy", 32'(slv_bus.resp.ar_ready), 32'd1);
    chk("ar1_id", 32'(mst_bus.req.ar.id), 32'd5);
    @(negedge clk);
    slv_bus.req.ar_valid = 1'b0;
    #1;
    chk("ar2_rdy", 32'(slv_bus.resp.ar_ready), 32'd0);
    chk("ar2_v", 32'(mst_bus.req.ar_valid), 32'd1);
    chk("ar2_id", 32'(mst_bus.req.ar.id), 32'd5);
    chk("ar2_idle", 32'(idle), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arr_v", 32'(mst_bus.req.ar_valid), 32'd0);
    chk("arr_idle", 32'(idle), 32'd1);
    chk("arr_rdy", 32'(slv_bus.resp.ar_ready), 32'd1);
    chk("arr_id", 32'(mst_bus.req.ar.id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mst_bus.resp.ar_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("arp_v", 32'(mst_bus.req.ar_valid), 32'd0);
      chk("arp_idle", 32'(idle), 32'd1);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
